hdmi_pattern_timing_gen: RTL and testbench

- Parametrised video timing and test-pattern generator. Drives the VGA-style parallel bus (HS/VS/DE/RGB) that feeds the TMDS encoder/serialiser stage of the HDMI output path.
- Successor to the fixed 720p pattern source. Resolution, sync polarity and colour depth are set by parameters.
- Adds a run-time pattern selector (switched only at frame boundary), an enable, pixel coordinate outputs, a frame-start strobe and an animated bouncing-box pattern.

---
 rtl/hdmi_pattern_timing_gen_if.sv | 24 ++
 rtl/hdmi_pattern_timing_gen.sv | 256 +++++++++++++++++++++++++
 tb/tb_hdmi_pattern_timing_gen.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/hdmi_pattern_timing_gen_if.sv
// Parallel video bus between the pattern/timing generator and the TMDS encoder stage.
// Carries syncs, data enable, RGB, pixel coordinates and the frame-start strobe.
interface hdmi_pattern_timing_gen_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 12
);
    logic              VGA_HS;
    logic              VGA_VS;
    logic              VGA_DE;
    logic [DATA_W-1:0] VGA_R;
    logic [DATA_W-1:0] VGA_G;
    logic [DATA_W-1:0] VGA_B;
    logic [CNT_W-1:0]  X_O;
    logic [CNT_W-1:0]  Y_O;
    logic              FRAME_START_O;

    modport master (
        output VGA_HS, VGA_VS, VGA_DE, VGA_R, VGA_G, VGA_B, X_O, Y_O, FRAME_START_O
    );

    modport slave (
        input VGA_HS, VGA_VS, VGA_DE, VGA_R, VGA_G, VGA_B, X_O, Y_O, FRAME_START_O
    );
endinterface

// File: rtl/hdmi_pattern_timing_gen.sv
// Parametrised video timing generator with selectable test patterns (bars, ramp,
// checkerboard, bouncing box). All outputs are registered one cycle after the counters.
module hdmi_pattern_timing_gen #(
    parameter int unsigned H_ACTIVE = 1280,
    parameter int unsigned H_FP     = 110,
    parameter int unsigned H_SYNC   = 40,
    parameter int unsigned H_BP     = 220,
    parameter int unsigned V_ACTIVE = 720,
    parameter int unsigned V_FP     = 5,
    parameter int unsigned V_SYNC   = 5,
    parameter int unsigned V_BP     = 20,
    parameter bit          HS_POL   = 1'b1,
    parameter bit          VS_POL   = 1'b1,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned BOX_SIZE = 64,
    parameter int unsigned CNT_W    = 12
) (
    input  logic                             PXLCLK_I,
    input  logic                             RST_I,
    input  logic                             EN_I,
    input  logic [2:0]                       MODE_I,
    hdmi_pattern_timing_gen_if.master        vga
);

    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;
    localparam int unsigned BAR_W    = H_ACTIVE / 8;

    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT_C    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_C    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START_C = CNT_W'(HS_START);
    localparam logic [CNT_W-1:0] HS_END_C   = CNT_W'(HS_END);
    localparam logic [CNT_W-1:0] VS_START_C = CNT_W'(VS_START);
    localparam logic [CNT_W-1:0] VS_END_C   = CNT_W'(VS_END);
    localparam logic [CNT_W-1:0] BAR_LAST   = CNT_W'(BAR_W - 1);
    localparam logic [CNT_W-1:0] BOX_X_MAX  = CNT_W'(H_ACTIVE - BOX_SIZE);
    localparam logic [CNT_W-1:0] BOX_Y_MAX  = CNT_W'(V_ACTIVE - BOX_SIZE);
    localparam logic [CNT_W:0]   BOX_EXT    = (CNT_W+1)'(BOX_SIZE);
    localparam logic [DATA_W-1:0] FULL      = {DATA_W{1'b1}};

    // Counter and pattern state
    logic [CNT_W-1:0]  h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0]  v_cnt_q, v_cnt_d;
    logic [2:0]        mode_q, mode_d;
    logic [2:0]        bar_idx_q, bar_idx_d;
    logic [CNT_W-1:0]  bar_px_q, bar_px_d;
    logic [CNT_W-1:0]  bx_q, bx_d;
    logic [CNT_W-1:0]  by_q, by_d;
    logic              dx_q, dx_d;
    logic              dy_q, dy_d;

    // Registered outputs
    logic              hs_q, hs_d;
    logic              vs_q, vs_d;
    logic              de_q, de_d;
    logic [DATA_W-1:0] r_q, r_d;
    logic [DATA_W-1:0] g_q, g_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [CNT_W-1:0]  x_q, x_d;
    logic [CNT_W-1:0]  y_q, y_d;
    logic              fs_q, fs_d;

    logic              h_last;
    logic              v_last;
    logic              frame_first;
    logic              in_box;
    logic [CNT_W:0]    box_x_end;
    logic [CNT_W:0]    box_y_end;

    assign h_last      = (h_cnt_q == H_LAST);
    assign v_last      = (v_cnt_q == V_LAST);
    assign frame_first = (h_cnt_q == '0) && (v_cnt_q == '0);
    assign box_x_end   = {1'b0, bx_q} + BOX_EXT;
    assign box_y_end   = {1'b0, by_q} + BOX_EXT;
    assign in_box      = (h_cnt_q >= bx_q) && ({1'b0, h_cnt_q} < box_x_end) &&
                         (v_cnt_q >= by_q) && ({1'b0, v_cnt_q} < box_y_end);

    // Timing counters, mode latch, bar tracker and box motion
    always_comb begin
        h_cnt_d   = h_last ? '0 : h_cnt_q + 1'b1;
        v_cnt_d   = v_cnt_q;
        mode_d    = mode_q;
        bar_idx_d = bar_idx_q;
        bar_px_d  = bar_px_q;
        bx_d      = bx_q;
        by_d      = by_q;
        dx_d      = dx_q;
        dy_d      = dy_q;

        if (h_last) begin
            v_cnt_d = v_last ? '0 : v_cnt_q + 1'b1;
        end

        // Mode taken on pixel (0,0) so the whole frame uses one pattern
        if (frame_first) begin
            mode_d = MODE_I;
        end

        if (h_last) begin
            bar_idx_d = '0;
            bar_px_d  = '0;
        end else if (bar_px_q == BAR_LAST) begin
            if (bar_idx_q != 3'd7) begin
                bar_idx_d = bar_idx_q + 3'd1;
                bar_px_d  = '0;
            end
        end else begin
            bar_px_d = bar_px_q + 1'b1;
        end

        if (h_last && v_last) begin
            if (dx_q) begin
                bx_d = bx_q + 1'b1;
                if (bx_d == BOX_X_MAX) dx_d = 1'b0;
            end else begin
                bx_d = bx_q - 1'b1;
                if (bx_d == '0) dx_d = 1'b1;
            end
            if (dy_q) begin
                by_d = by_q + 1'b1;
                if (by_d == BOX_Y_MAX) dy_d = 1'b0;
            end else begin
                by_d = by_q - 1'b1;
                if (by_d == '0) dy_d = 1'b1;
            end
        end

        if (!EN_I) begin
            h_cnt_d   = '0;
            v_cnt_d   = '0;
            mode_d    = '0;
            bar_idx_d = '0;
            bar_px_d  = '0;
            bx_d      = '0;
            by_d      = '0;
            dx_d      = 1'b1;
            dy_d      = 1'b1;
        end
    end

    // Output stage: decode of the current counter state, registered below
    always_comb begin
        hs_d = ((h_cnt_q >= HS_START_C) && (h_cnt_q < HS_END_C)) ? HS_POL : ~HS_POL;
        vs_d = ((v_cnt_q >= VS_START_C) && (v_cnt_q < VS_END_C)) ? VS_POL : ~VS_POL;
        de_d = (h_cnt_q < H_ACT_C) && (v_cnt_q < V_ACT_C);
        x_d  = h_cnt_q;
        y_d  = v_cnt_q;
        fs_d = frame_first;
        r_d  = '0;
        g_d  = '0;
        b_d  = '0;

        if (de_d) begin
            unique case (mode_d)
                3'd0: begin
                    r_d = {DATA_W{~bar_idx_q[1]}};
                    g_d = {DATA_W{~bar_idx_q[2]}};
                    b_d = {DATA_W{~bar_idx_q[0]}};
                end
                3'd1: begin
                    r_d = DATA_W'(h_cnt_q);
                    g_d = DATA_W'(h_cnt_q);
                    b_d = DATA_W'(h_cnt_q);
                end
                3'd2: begin
                    if (!(h_cnt_q[5] ^ v_cnt_q[5])) begin
                        r_d = FULL;
                        g_d = FULL;
                        b_d = FULL;
                    end
                end
                3'd3: begin
                    r_d = in_box ? FULL : '0;
                    g_d = in_box ? FULL : '0;
                    b_d = FULL;
                end
                default: begin
                    r_d = '0;
                    g_d = '0;
                    b_d = '0;
                end
            endcase
        end

        if (!EN_I) begin
            hs_d = ~HS_POL;
            vs_d = ~VS_POL;
            de_d = 1'b0;
            x_d  = '0;
            y_d  = '0;
            fs_d = 1'b0;
            r_d  = '0;
            g_d  = '0;
            b_d  = '0;
        end
    end

    always_ff @(posedge PXLCLK_I or posedge RST_I) begin
        if (RST_I) begin
            h_cnt_q   <= '0;
            v_cnt_q   <= '0;
            mode_q    <= '0;
            bar_idx_q <= '0;
            bar_px_q  <= '0;
            bx_q      <= '0;
            by_q      <= '0;
            dx_q      <= 1'b1;
            dy_q      <= 1'b1;
            hs_q      <= ~HS_POL;
            vs_q      <= ~VS_POL;
            de_q      <= 1'b0;
            r_q       <= '0;
            g_q       <= '0;
            b_q       <= '0;
            x_q       <= '0;
            y_q       <= '0;
            fs_q      <= 1'b0;
        end else begin
            h_cnt_q   <= h_cnt_d;
            v_cnt_q   <= v_cnt_d;
            mode_q    <= mode_d;
            bar_idx_q <= bar_idx_d;
            bar_px_q  <= bar_px_d;
            bx_q      <= bx_d;
            by_q      <= by_d;
            dx_q      <= dx_d;
            dy_q      <= dy_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            de_q      <= de_d;
            r_q       <= r_d;
            g_q       <= g_d;
            b_q       <= b_d;
            x_q       <= x_d;
            y_q       <= y_d;
            fs_q      <= fs_d;
        end
    end

    assign vga.VGA_HS        = hs_q;
    assign vga.VGA_VS        = vs_q;
    assign vga.VGA_DE        = de_q;
    assign vga.VGA_R         = r_q;
    assign vga.VGA_G         = g_q;
    assign vga.VGA_B         = b_q;
    assign vga.X_O           = x_q;
    assign vga.Y_O           = y_q;
    assign vga.FRAME_START_O = fs_q;

endmodule

// File: tb/tb_hdmi_pattern_timing_gen.sv
// Scoreboard bench: two generator instances (tiny timing and small box geometry) checked
// every cycle against a frame-arithmetic reference model.
module tb_hdmi_pattern_timing_gen;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic [7:0]  r;
        logic [7:0]  g;
        logic [7:0]  b;
        logic [11:0] x;
        logic [11:0] y;
        logic        fs;
    } pix_t;

    typedef struct {
        int ha, hfp, hsw, hbp, va, vfp, vsw, vbp, box;
        bit hpol, vpol;
        int h, v, mode, frames;
    } model_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [2:0] mode_a;
    logic [2:0] mode_b;

    int   checks = 0;
    int   errors = 0;
    bit   done   = 1'b0;
    pix_t qa[$];
    pix_t qb[$];
    model_t ma, mb;

    always #5 clk = ~clk;

    hdmi_pattern_timing_gen_if #(.DATA_W(8), .CNT_W(12)) vif_a ();
    hdmi_pattern_timing_gen_if #(.DATA_W(8), .CNT_W(12)) vif_b ();

    hdmi_pattern_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
        .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b0), .DATA_W(8), .BOX_SIZE(4), .CNT_W(12)
    ) dut_a (
        .PXLCLK_I(clk), .RST_I(rst), .EN_I(en), .MODE_I(mode_a), .vga(vif_a)
    );

    hdmi_pattern_timing_gen #(
        .H_ACTIVE(40), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_ACTIVE(36), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .DATA_W(8), .BOX_SIZE(32), .CNT_W(12)
    ) dut_b (
        .PXLCLK_I(clk), .RST_I(rst), .EN_I(en), .MODE_I(mode_b), .vga(vif_b)
    );

    task automatic finish_sim();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
            if (errors >= 50) finish_sim();
        end
    endtask

    function automatic model_t mk(input int ha, hfp, hsw, hbp, va, vfp, vsw, vbp, box,
                                  input bit hp, vp);
        model_t m;
        m.ha = ha; m.hfp = hfp; m.hsw = hsw; m.hbp = hbp;
        m.va = va; m.vfp = vfp; m.vsw = vsw; m.vbp = vbp;
        m.box = box; m.hpol = hp; m.vpol = vp;
        m.h = 0; m.v = 0; m.mode = 0; m.frames = 0;
        return m;
    endfunction

    // Triangle wave: position after n frame steps bouncing between 0 and lim
    function automatic int tri_pos(input int n, input int lim);
        int p;
        p = n % (2 * lim);
        return (p <= lim) ? p : 2 * lim - p;
    endfunction

    function automatic logic [23:0] bar_rgb(input int idx);
        case (idx)
            0: return 24'hFFFFFF;
            1: return 24'hFFFF00;
            2: return 24'h00FFFF;
            3: return 24'h00FF00;
            4: return 24'hFF00FF;
            5: return 24'hFF0000;
            6: return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    // Expected output for one clock edge, then advance the model
    task automatic step(inout model_t m, input bit e, input bit r, input int mode_in,
                        output pix_t p);
        int ht, vt, idx, bx, by;
        p = '0;
        if (r || !e) begin
            p.hs = !m.hpol;
            p.vs = !m.vpol;
            m.h = 0; m.v = 0; m.mode = 0; m.frames = 0;
        end else begin
            ht = m.ha + m.hfp + m.hsw + m.hbp;
            vt = m.va + m.vfp + m.vsw + m.vbp;
            if (m.h == 0 && m.v == 0) m.mode = mode_in;
            p.x  = 12'(m.h);
            p.y  = 12'(m.v);
            p.fs = (m.h == 0 && m.v == 0);
            p.hs = (m.h >= m.ha + m.hfp && m.h < m.ha + m.hfp + m.hsw) ? m.hpol : !m.hpol;
            p.vs = (m.v >= m.va + m.vfp && m.v < m.va + m.vfp + m.vsw) ? m.vpol : !m.vpol;
            p.de = (m.h < m.ha) && (m.v < m.va);
            if (p.de) begin
                case (m.mode)
                    0: begin
                        idx = m.h / (m.ha / 8);
                        if (idx > 7) idx = 7;
                        {p.r, p.g, p.b} = bar_rgb(idx);
                    end
                    1: {p.r, p.g, p.b} = {3{8'(m.h % 256)}};
                    2: {p.r, p.g, p.b} = (((m.h / 32) + (m.v / 32)) % 2 == 0) ? 24'hFFFFFF : 24'h0;
                    3: begin
                        bx = tri_pos(m.frames, m.ha - m.box);
                        by = tri_pos(m.frames, m.va - m.box);
                        if (m.h >= bx && m.h < bx + m.box && m.v >= by && m.v < by + m.box)
                            {p.r, p.g, p.b} = 24'hFFFFFF;
                        else
                            {p.r, p.g, p.b} = 24'h0000FF;
                    end
                    default: {p.r, p.g, p.b} = 24'h0;
                endcase
            end
            m.h++;
            if (m.h == ht) begin
                m.h = 0;
                m.v++;
                if (m.v == vt) begin
                    m.v = 0;
                    m.frames++;
                end
            end
        end
    endtask

    task automatic cycle(input bit e, input bit r, input logic [2:0] a, input logic [2:0] b);
        pix_t pa, pb;
        en = e; rst = r; mode_a = a; mode_b = b;
        step(ma, e, r, int'(a), pa);
        qa.push_back(pa);
        step(mb, e, r, int'(b), pb);
        qb.push_back(pb);
        @(negedge clk);
    endtask

    // Reset raised between clock edges: outputs must go idle without waiting for a clock
    task automatic async_reset_check();
        pix_t pa, pb;
        #2 rst = 1'b1;
        #1;
        chk("async_rst_hs_a", 64'(vif_a.VGA_HS), 64'd0);
        chk("async_rst_vs_a", 64'(vif_a.VGA_VS), 64'd1);
        chk("async_rst_de_a", 64'(vif_a.VGA_DE), 64'd0);
        chk("async_rst_rgb_a", 64'({vif_a.VGA_R, vif_a.VGA_G, vif_a.VGA_B}), 64'd0);
        chk("async_rst_vs_b", 64'(vif_b.VGA_VS), 64'd0);
        step(ma, en, 1'b1, int'(mode_a), pa);
        qa.push_back(pa);
        step(mb, en, 1'b1, int'(mode_b), pb);
        qb.push_back(pb);
        @(negedge clk);
    endtask

    // Monitor: pops one expectation per DUT per edge
    int a_period = 0;
    int a_de     = 0;
    bit a_valid  = 1'b0;

    initial begin
        pix_t got, exp;
        forever begin
            @(posedge clk);
            #1;
            if (!done) begin
                if (qa.size() == 0 || qb.size() == 0) begin
                    chk("scoreboard_underflow", 64'd1, 64'd0);
                end else begin
                    exp = qa.pop_front();
                    got = {vif_a.VGA_HS, vif_a.VGA_VS, vif_a.VGA_DE, vif_a.VGA_R, vif_a.VGA_G,
                           vif_a.VGA_B, vif_a.X_O, vif_a.Y_O, vif_a.FRAME_START_O};
                    chk("pixel_a", 64'(got), 64'(exp));
                    exp = qb.pop_front();
                    got = {vif_b.VGA_HS, vif_b.VGA_VS, vif_b.VGA_DE, vif_b.VGA_R, vif_b.VGA_G,
                           vif_b.VGA_B, vif_b.X_O, vif_b.Y_O, vif_b.FRAME_START_O};
                    chk("pixel_b", 64'(got), 64'(exp));
                end
                if (rst || !en) begin
                    a_valid = 1'b0;
                end else begin
                    if (vif_a.FRAME_START_O) begin
                        if (a_valid) begin
                            chk("frame_period_a", 64'(a_period), 64'd300);
                            chk("frame_de_count_a", 64'(a_de), 64'd128);
                        end
                        a_valid  = 1'b1;
                        a_period = 0;
                        a_de     = 0;
                    end
                    a_period++;
                    if (vif_a.VGA_DE) a_de++;
                end
            end
        end
    end

    initial begin
        ma = mk(16, 2, 3, 4, 8, 1, 2, 1, 4, 1'b1, 1'b0);
        mb = mk(40, 1, 1, 1, 36, 1, 1, 1, 32, 1'b1, 1'b1);
        repeat (3) cycle(1'b0, 1'b1, 3'd0, 3'd0);
        repeat (3) cycle(1'b0, 1'b0, 3'd0, 3'd3);
        repeat (4000) cycle(1'b1, 1'b0, 3'd0, 3'd3);

        // Mid-line asynchronous reset
        while (ma.h != 7) cycle(1'b1, 1'b0, 3'd0, 3'd3);
        async_reset_check();
        repeat (2) cycle(1'b1, 1'b1, 3'd0, 3'd3);

        // B shows bars, switches to checkerboard mid-frame
        repeat (800) cycle(1'b1, 1'b0, 3'd1, 3'd0);
        repeat (3354) cycle(1'b1, 1'b0, 3'd1, 3'd2);

        // Enable dropped mid-frame for 5 clocks
        repeat (5) cycle(1'b0, 1'b0, 3'd1, 3'd2);

        // Long box run so the box bounces on both axes
        repeat (33540) cycle(1'b1, 1'b0, 3'($urandom_range(0, 7)), 3'd3);

        // Random modes with occasional enable drops
        for (int i = 0; i < 6000; i++) begin
            cycle(($urandom_range(0, 499) != 0), 1'b0, 3'($urandom_range(0, 7)),
                  3'($urandom_range(0, 7)));
        end
        done = 1'b1;
        finish_sim();
    end

endmodule
